// File: rtl/dbus_mem_responder_pkg.sv
// Shared data-bus types for the memory responder and its RAM array.
// Also holds the byte-lane merge helper used when committing writes.
package dbus_mem_responder_pkg;

   typedef enum logic [2:0] {
      Msize1,
      Msize2,
      Msize4,
      Msize8
   } msize_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   function automatic logic [63:0] strobe_merge(input logic [63:0] old_word,
                                                input logic [63:0] new_word,
                                                input logic [7:0]  strobe);
      logic [63:0] merged;
      merged = old_word;
      for (int i = 0; i < 8; i++) begin
         if (strobe[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/dbus_sram_array.sv
// DEPTH x 64-bit word RAM: combinational read port, byte-strobed synchronous write port.
// Contents are intentionally not reset.
module dbus_sram_array
   import dbus_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   localparam int unsigned IdxW = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            we,
   input  logic [IdxW-1:0] idx,
   input  logic [7:0]      wstrb,
   input  logic [63:0]     wdata,
   output logic [63:0]     rdata
);

   logic [63:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[idx] <= strobe_merge(mem[idx], wdata, wstrb);
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dbus_mem_responder.sv
// Data-bus memory responder: captures one request, waits LATENCY cycles, then returns a
// registered one-cycle response and commits any write to the backing RAM.
module dbus_mem_responder
   import dbus_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH   = 1024,
   parameter logic [63:0] BASE    = 64'h8000_0000,
   parameter int unsigned LATENCY = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp,
   output logic       oob
);

   localparam int unsigned IdxW   = $clog2(DEPTH);
   localparam logic [63:0] Limit  = BASE + 64'(DEPTH) * 64'd8;
   localparam logic [3:0]  LatCnt = 4'(LATENCY);

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] addr_q, data_q;
   logic [7:0]  strobe_q;
   msize_t      size_q;
   dbus_resp_t  resp_q, resp_d;
   logic        oob_q, oob_d;
   logic        capture;

   logic [63:0]     cur_addr, cur_off, rdata;
   logic            cur_write, cur_inrange, we;
   logic [IdxW-1:0] cur_idx;

   // While idle the live request drives the RAM port so LATENCY==0 can answer next cycle.
   always_comb begin
      cur_addr    = (state_q == StIdle) ? dreq.addr : addr_q;
      cur_write   = (state_q == StIdle) ? |dreq.strobe : |strobe_q;
      cur_off     = cur_addr - BASE;
      cur_idx     = cur_off[IdxW+2:3];
      cur_inrange = (cur_addr >= BASE) && (cur_addr < Limit);
   end

   assign we = (state_q == StResp) && cur_write && cur_inrange;

   dbus_sram_array #(
      .DEPTH (DEPTH)
   ) u_sram (
      .clk   (clk),
      .we    (we),
      .idx   (cur_idx),
      .wstrb (strobe_q),
      .wdata (data_q),
      .rdata (rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      resp_d  = '0;
      oob_d   = oob_q;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (dreq.valid) begin
               capture = 1'b1;
               cnt_d   = LatCnt;
               state_d = (LATENCY == 0) ? StResp : StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = StResp;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Response register is loaded on the edge that enters StResp.
      if (state_d == StResp) begin
         resp_d.addr_ok = 1'b1;
         resp_d.data_ok = 1'b1;
         resp_d.data    = (cur_inrange && !cur_write) ? rdata : '0;
         if (!cur_inrange) oob_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         resp_q   <= '0;
         oob_q    <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         strobe_q <= '0;
         size_q   <= Msize1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
         oob_q   <= oob_d;
         if (capture) begin
            addr_q   <= dreq.addr;
            data_q   <= dreq.data;
            strobe_q <= dreq.strobe;
            size_q   <= dreq.size;
         end
      end
   end

   assign dresp = resp_q;
   assign oob   = oob_q;

   // size is kept for debug visibility only; offset bits outside the index are don't-care.
   logic unused_bits;
   assign unused_bits = ^{size_q, cur_off[63:IdxW+3], cur_off[2:0]};

endmodule
